divider_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one iterative `division` unit between several requesters, such as the period-to-frequency path and a secondary ratio/scaling path. It grants one requester at a time and latches that requester's operands. It then drives the divider's start/operand ports, waits for the divider's done with a watchdog, and returns the quotient plus an error flag to the granted requester. Divide-by-zero is trapped locally and never reaches the divider.

---
 rtl/divider_arbiter_if.sv | 33 +++
 rtl/divider_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_divider_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter_if
// Brief    : Requester-side bus of the divider arbiter: per-requester request
//            levels with packed operands, and the shared response signals.
// Revision : 1.0 - initial release
// ============================================================================
interface divider_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int DW    = 32,
  parameter int QW    = 24
);
  logic [N_REQ-1:0]    req_i;
  logic [N_REQ*DW-1:0] dividend_i;
  logic [N_REQ*DW-1:0] divisor_i;
  logic [N_REQ-1:0]    ack_o;
  logic [N_REQ-1:0]    done_o;
  logic [QW-1:0]       quotient_o;
  logic                err_o;

  // Requesters drive requests/operands and observe the responses.
  modport master (
    output req_i, dividend_i, divisor_i,
    input  ack_o, done_o, quotient_o, err_o
  );

  // The arbiter observes requests/operands and drives the responses.
  modport slave (
    input  req_i, dividend_i, divisor_i,
    output ack_o, done_o, quotient_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one iterative divider
//            between N_REQ requesters, with local divide-by-zero trap and a
//            watchdog on the divider's done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module divider_arbiter #(
  parameter int N_REQ   = 2,
  parameter int DW      = 32,
  parameter int QW      = 24,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  divider_arbiter_if.slave req_if,
  output logic             busy_o,
  output logic             div_start_o,
  output logic [DW-1:0]    div_dividend_o,
  output logic [DW-1:0]    div_divisor_o,
  input  logic [QW-1:0]    div_quotient_i,
  input  logic             div_done_i
);

  localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WDOG_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] last_q, last_d;
  logic [DW-1:0]      dividend_q, dividend_d;
  logic [DW-1:0]      divisor_q, divisor_d;
  logic               zero_q, zero_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [QW-1:0]      quotient_q, quotient_d;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   done;
  logic               start;

  logic [DW-1:0]      dividend_arr [N_REQ];
  logic [DW-1:0]      divisor_arr  [N_REQ];

  logic               hi_found, lo_found;
  logic [OWNER_W-1:0] hi_idx, lo_idx;
  logic [OWNER_W-1:0] grant_idx;
  logic               any_req;

  // Unpack the flat operand buses into per-requester arrays.
  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign dividend_arr[k] = req_if.dividend_i[k*DW +: DW];
    assign divisor_arr[k]  = req_if.divisor_i[k*DW +: DW];
  end

  // Round-robin pick: lowest requester above `last`, else lowest at/below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_if.req_i[k]) begin
        if (OWNER_W'(k) > last_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = OWNER_W'(k);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = OWNER_W'(k);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    any_req   = |req_if.req_i;
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    zero_d     = zero_q;
    wdog_d     = wdog_q;
    quotient_d = quotient_q;
    err_d      = err_q;
    ack        = '0;
    done       = '0;
    start      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d    = grant_idx;
          last_d     = grant_idx;
          dividend_d = dividend_arr[grant_idx];
          divisor_d  = divisor_arr[grant_idx];
          zero_d     = (divisor_arr[grant_idx] == '0);
          state_d    = S_START;
        end
      end
      S_START: begin
        ack[owner_q] = 1'b1;
        start        = !zero_q;
        if (zero_q) begin
          // Zero divisor never reaches the divider; answer with saturation.
          quotient_d = '1;
          err_d      = 1'b1;
          state_d    = S_RESP;
        end else begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wdog_d = wdog_q + WDOG_W'(1);
        // A done landing on the last watchdog cycle still counts as success.
        if (div_done_i) begin
          quotient_d = div_quotient_i;
          err_d      = 1'b0;
          state_d    = S_RESP;
        end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          quotient_d = '1;
          err_d      = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        done[owner_q] = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation silently.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      last_q     <= OWNER_W'(N_REQ - 1);
      dividend_q <= '0;
      divisor_q  <= '0;
      zero_q     <= 1'b0;
      wdog_q     <= '0;
      quotient_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      zero_q     <= zero_d;
      wdog_q     <= wdog_d;
      quotient_q <= quotient_d;
      err_q      <= err_d;
    end
  end

  assign req_if.ack_o      = ack;
  assign req_if.done_o     = done;
  assign req_if.quotient_o = quotient_q;
  assign req_if.err_o      = err_q;
  assign busy_o            = (state_q != S_IDLE);
  assign div_start_o       = start;
  assign div_dividend_o    = dividend_q;
  assign div_divisor_o     = divisor_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_arbiter
// Brief    : Directed self-checking bench for divider_arbiter with a simple
//            fixed-latency divider model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_arbiter;

  localparam int N_REQ   = 2;
  localparam int DW      = 32;
  localparam int QW      = 24;
  localparam int TIMEOUT = 64;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          busy_o;
  logic          div_start_o;
  logic [DW-1:0] div_dividend_o;
  logic [DW-1:0] div_divisor_o;
  logic [QW-1:0] div_quotient_i;
  logic          div_done_i;

  divider_arbiter_if #(.N_REQ(N_REQ), .DW(DW), .QW(QW)) bus ();

  divider_arbiter #(
    .N_REQ(N_REQ), .DW(DW), .QW(QW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .req_if         (bus),
    .busy_o         (busy_o),
    .div_start_o    (div_start_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_quotient_i (div_quotient_i),
    .div_done_i     (div_done_i)
  );

  always #5 clk_i = ~clk_i;

  // Divider model: done pulse model_lat cycles after start (0 = never).
  int            model_lat;
  logic          m_active;
  int            m_cnt;
  logic          m_done;
  logic [QW-1:0] m_q;
  logic          tb_done;

  assign div_done_i     = m_done | tb_done;
  assign div_quotient_i = m_q;

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
      m_done   <= 1'b0;
      m_q      <= '0;
    end else begin
      m_done <= 1'b0;
      if (div_start_o) begin
        m_active <= 1'b1;
        m_cnt    <= 1;
        m_q      <= (div_divisor_o != 0) ? QW'(div_dividend_o / div_divisor_o) : '1;
      end else if (m_active) begin
        if (model_lat != 0 && m_cnt == model_lat - 1) begin
          m_done   <= 1'b1;
          m_active <= 1'b0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc;
  int n_start;
  int n_done;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (div_start_o) n_start++;
    if (bus.done_o != '0) n_done++;
  endtask

  task automatic begin_op();
    cyc     = 0;
    n_start = 0;
    n_done  = 0;
  endtask

  task automatic wait_ack(output int at, output logic [N_REQ-1:0] v);
    int i;
    at = -1;
    v  = '0;
    i  = 0;
    while (at < 0 && i < 200) begin
      tick();
      i++;
      if (bus.ack_o != '0) begin
        at = cyc;
        v  = bus.ack_o;
      end
    end
  endtask

  task automatic wait_done(output int at, output logic [N_REQ-1:0] v,
                           output logic [QW-1:0] q, output logic e);
    int i;
    at = -1;
    v  = '0;
    q  = '0;
    e  = 1'b0;
    i  = 0;
    while (at < 0 && i < 300) begin
      tick();
      i++;
      if (bus.done_o != '0) begin
        at = cyc;
        v  = bus.done_o;
        q  = bus.quotient_o;
        e  = bus.err_o;
      end
    end
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int               at;
    logic [N_REQ-1:0] v;
    logic [QW-1:0]    q;
    logic             e;

    reset_ni       = 1'b0;
    bus.req_i      = '0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    model_lat      = 30;
    tb_done        = 1'b0;
    cyc            = 0;
    n_start        = 0;
    n_done         = 0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_ack",   bus.ack_o, 0);
    check_eq("rst_done",  bus.done_o, 0);
    check_eq("rst_busy",  busy_o, 0);
    check_eq("rst_start", div_start_o, 0);
    check_eq("rst_quot",  bus.quotient_o, 0);
    check_eq("rst_err",   bus.err_o, 0);
    reset_ni = 1'b1;

    // Single request: 1000000 / 250000, divider latency 30
    bus.req_i      = 2'b01;
    bus.dividend_i = {32'd0, 32'd1000000};
    bus.divisor_i  = {32'd0, 32'd250000};
    model_lat      = 30;
    begin_op();
    tick();
    check_eq("t1_ack",     bus.ack_o, 2'b01);
    check_eq("t1_start",   div_start_o, 1);
    check_eq("t1_busy",    busy_o, 1);
    check_eq("t1_divisor", div_divisor_o, 250000);
    bus.req_i = 2'b00;
    wait_done(at, v, q, e);
    check_eq("t1_done_cyc", at, 32);
    check_eq("t1_done",     v, 2'b01);
    check_eq("t1_quot",     q, 4);
    check_eq("t1_err",      e, 0);
    check_eq("t1_nstart",   n_start, 1);
    tick();
    check_eq("t1_idle_busy", busy_o, 0);

    // Simultaneous requests held through reset: grants 0, 1, 0
    bus.req_i      = 2'b11;
    bus.dividend_i = {32'd1000000, 32'd1000000};
    bus.divisor_i  = {32'd7, 32'd3};
    model_lat      = 5;
    do_reset();
    begin_op();
    wait_ack(at, v);
    check_eq("t2_ack1_cyc", at, 1);
    check_eq("t2_ack1",     v, 2'b01);
    wait_done(at, v, q, e);
    check_eq("t2_done1_cyc", at, 7);
    check_eq("t2_done1",     v, 2'b01);
    check_eq("t2_quot1",     q, 333333);
    wait_ack(at, v);
    check_eq("t2_ack2_cyc", at, 9);
    check_eq("t2_ack2",     v, 2'b10);
    wait_done(at, v, q, e);
    check_eq("t2_done2", v, 2'b10);
    check_eq("t2_quot2", q, 142857);
    check_eq("t2_err2",  e, 0);
    wait_ack(at, v);
    check_eq("t2_ack3", v, 2'b01);
    wait_done(at, v, q, e);
    bus.req_i = 2'b00;
    check_eq("t2_done3",  v, 2'b01);
    check_eq("t2_quot3",  q, 333333);
    check_eq("t2_ndone",  n_done, 3);
    tick();

    // Zero divisor on requester 1
    bus.req_i      = 2'b10;
    bus.dividend_i = {32'd1234, 32'd0};
    bus.divisor_i  = {32'd0, 32'd0};
    begin_op();
    tick();
    check_eq("t3_ack",   bus.ack_o, 2'b10);
    check_eq("t3_start", div_start_o, 0);
    bus.req_i = 2'b00;
    tick();
    check_eq("t3_done",   bus.done_o, 2'b10);
    check_eq("t3_quot",   bus.quotient_o, 24'hFFFFFF);
    check_eq("t3_err",    bus.err_o, 1);
    check_eq("t3_nstart", n_start, 0);
    tick();

    // Timeout: divider never answers; late done at cycle 70 ignored
    bus.req_i      = 2'b01;
    bus.dividend_i = {32'd0, 32'd100};
    bus.divisor_i  = {32'd0, 32'd10};
    model_lat      = 0;
    begin_op();
    wait_ack(at, v);
    check_eq("t4_ack", v, 2'b01);
    bus.req_i = 2'b00;
    wait_done(at, v, q, e);
    check_eq("t4_done_cyc", at, TIMEOUT + 2);
    check_eq("t4_done",     v, 2'b01);
    check_eq("t4_quot",     q, 24'hFFFFFF);
    check_eq("t4_err",      e, 1);
    n_done = 0;
    while (cyc < 70) tick();
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    repeat (2) tick();
    check_eq("t4_late_ndone", n_done, 0);
    check_eq("t4_late_busy",  busy_o, 0);
    check_eq("t4_late_quot",  bus.quotient_o, 24'hFFFFFF);
    check_eq("t4_late_err",   bus.err_o, 1);

    // Done arrives exactly on the last watchdog cycle
    bus.req_i      = 2'b01;
    bus.dividend_i = {32'd0, 32'd1000};
    bus.divisor_i  = {32'd0, 32'd8};
    model_lat      = TIMEOUT;
    begin_op();
    wait_ack(at, v);
    bus.req_i = 2'b00;
    wait_done(at, v, q, e);
    check_eq("t5_done_cyc", at, TIMEOUT + 2);
    check_eq("t5_quot",     q, 125);
    check_eq("t5_err",      e, 0);
    tick();

    // Reset in the middle of WAIT, then requester 1 alone
    bus.req_i      = 2'b01;
    bus.dividend_i = {32'd0, 32'd1000000};
    bus.divisor_i  = {32'd0, 32'd250000};
    model_lat      = 30;
    begin_op();
    wait_ack(at, v);
    bus.req_i = 2'b00;
    while (cyc < 10) tick();
    reset_ni = 1'b0;
    #1;
    check_eq("t6_busy",     busy_o, 0);
    check_eq("t6_start",    div_start_o, 0);
    check_eq("t6_ack",      bus.ack_o, 0);
    check_eq("t6_done",     bus.done_o, 0);
    check_eq("t6_quot",     bus.quotient_o, 0);
    check_eq("t6_err",      bus.err_o, 0);
    check_eq("t6_dividend", div_dividend_o, 0);
    check_eq("t6_divisor",  div_divisor_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    bus.req_i      = 2'b10;
    bus.dividend_i = {32'd1000000, 32'd0};
    bus.divisor_i  = {32'd7, 32'd0};
    reset_ni       = 1'b1;
    begin_op();
    wait_ack(at, v);
    check_eq("t6_ack_cyc", at, 1);
    check_eq("t6_ack_req1", v, 2'b10);
    bus.req_i = 2'b00;
    wait_done(at, v, q, e);
    check_eq("t6_done_cyc", at, 32);
    check_eq("t6_done_req1", v, 2'b10);
    check_eq("t6_quot_req1", q, 142857);
    check_eq("t6_err_req1",  e, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
